m72_irq_ctrl: RTL and testbench

M72_IRQ_CTRL -- requirements
Module: m72_irq_ctrl

---
 rtl/m72_irq_ctrl_if.sv | 24 ++
 rtl/m72_irq_ctrl.sv | 152 +++++++++++++++
 tb/tb_m72_irq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m72_irq_ctrl_if.sv
// Wishbone slave bus bundle for the M72 interrupt controller.
// The master (CPU) drives strobe, cycle, tags, address and data; the controller returns data and ack.
interface m72_irq_ctrl_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_tga_i;
    logic        wb_tgc_i;
    logic [2:1]  wb_adr_i;
    logic [1:0]  wb_sel_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_tga_i, wb_tgc_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_tga_i, wb_tgc_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/m72_irq_ctrl.sv
// M72 edge-triggered 8-level interrupt controller with fixed priority (bit 0 highest).
// Define M72_IRQ_ISR_EN to add an in-service register with EOI and nested-priority blocking.
module m72_irq_ctrl (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    m72_irq_ctrl_if.slave wb,
    input  logic [7:0]    irq_in,
    output logic          int_rq
);
    typedef enum logic [1:0] {StIdle, StWait, StAck} bus_state_e;

    bus_state_e  state_q, state_d;
    logic [7:0]  irq_sync_q, irq_dly_q, irq_edge;
    logic [1:0]  sync_vld_q;
    logic [4:0]  vbase_q, vbase_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  blocked, isr_rd;
    logic [7:0]  eligible, grant;
    logic [2:0]  level;
    logic        access, is_iack, reg_wr;
    logic [15:0] rdata, dat_q, dat_d;
    logic        int_rq_q;
    logic        unused_bits;

    assign unused_bits = ^{wb.wb_sel_i[1], wb.wb_dat_i[15:8]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (wb.wb_stb_i && wb.wb_cyc_i && (wb.wb_tga_i || wb.wb_tgc_i)) begin
                    state_d = StWait;
                end
            end
            StWait:  state_d = wb.wb_stb_i ? StAck : StIdle;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // All register side effects happen on the WAIT->ACK edge.
    assign access  = (state_q == StWait) && wb.wb_stb_i;
    assign is_iack = access && wb.wb_tgc_i;
    assign reg_wr  = access && !wb.wb_tgc_i && wb.wb_we_i && wb.wb_sel_i[0];

    // Edges are only trusted once both sync stages hold post-reset samples.
    assign irq_edge = irq_sync_q & ~irq_dly_q & {8{sync_vld_q[1]}};

`ifdef M72_IRQ_ISR_EN
    logic [7:0] isr_q, isr_d;

    always_comb begin
        isr_d = isr_q;
        if (is_iack) begin
            isr_d = isr_q | grant;
        end
        if (reg_wr && (wb.wb_adr_i == 2'd3)) begin
            isr_d = isr_q & (isr_q - 8'd1);
        end
    end

    // Block the highest in-service level and everything below it.
    assign blocked = ~((isr_q & (~isr_q + 8'd1)) - 8'd1);
    assign isr_rd  = isr_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            isr_q <= '0;
        end else begin
            isr_q <= isr_d;
        end
    end
`else
    assign blocked = '0;
    assign isr_rd  = '0;
`endif

    assign eligible = pend_q & ~mask_q & ~blocked;
    assign grant    = eligible & (~eligible + 8'd1);

    always_comb begin
        level = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                level = i[2:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (wb.wb_tgc_i) begin
            rdata = {8'h00, vbase_q, level};
        end else if (!wb.wb_we_i) begin
            case (wb.wb_adr_i)
                2'd0:    rdata = {8'h00, vbase_q, 3'b000};
                2'd1:    rdata = {8'h00, mask_q};
                2'd2:    rdata = {8'h00, pend_q};
                default: rdata = {8'h00, isr_rd};
            endcase
        end
        dat_d = access ? rdata : '0;
    end

    always_comb begin
        vbase_d = vbase_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        if (reg_wr) begin
            case (wb.wb_adr_i)
                2'd0:    vbase_d = wb.wb_dat_i[7:3];
                2'd1:    mask_d  = wb.wb_dat_i[7:0];
                2'd2:    pend_d  = pend_q & ~wb.wb_dat_i[7:0];
                default: ;
            endcase
        end
        if (is_iack) begin
            pend_d = pend_d & ~grant;
        end
        // A fresh edge beats any clear on the same cycle.
        pend_d = pend_d | irq_edge;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            irq_sync_q <= '0;
            irq_dly_q  <= '0;
            sync_vld_q <= '0;
            vbase_q    <= 5'b00100;
            mask_q     <= 8'hFF;
            pend_q     <= '0;
            dat_q      <= '0;
            int_rq_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_sync_q <= irq_in;
            irq_dly_q  <= irq_sync_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            vbase_q    <= vbase_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            dat_q      <= dat_d;
            int_rq_q   <= |eligible;
        end
    end

    assign wb.wb_ack_o = (state_q == StAck);
    assign wb.wb_dat_o = dat_q;
    assign int_rq      = int_rq_q;
endmodule

// File: tb/tb_m72_irq_ctrl.sv
// Scoreboard bench for m72_irq_ctrl: stimulus queues expected ack data, a monitor pops on each ack.
module tb_m72_irq_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic       int_rq;

    m72_irq_ctrl_if bus ();

    m72_irq_ctrl dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus),
        .irq_in   (irq_in),
        .int_rq   (int_rq)
    );

    typedef struct {
        logic        chk;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry.
    always @(negedge clk) begin
        if (bus.wb_ack_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: got ack with data %h, want no ack", bus.wb_dat_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.chk) chk(e.name, bus.wb_dat_o, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic we, input logic tga, input logic tgc, input logic [1:0] adr,
                        input logic [1:0] sel, input logic [15:0] dat, input logic chk_d,
                        input logic [15:0] exp, input string name);
        exp_t e;
        e.chk = chk_d;
        e.val = exp;
        e.name = name;
        tick();
        sb_q.push_back(e);
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_tga_i = tga;
        bus.wb_tgc_i = tgc;
        bus.wb_adr_i = adr;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
        tick();
        chk({name, "_lat1"}, {15'd0, bus.wb_ack_o}, 16'd0);
        tick();
        chk({name, "_lat2"}, {15'd0, bus.wb_ack_o}, 16'd1);
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_tga_i = 1'b0;
        bus.wb_tgc_i = 1'b0;
    endtask

    task automatic rd(input logic [1:0] adr, input logic [15:0] exp, input string name);
        xfer(1'b0, 1'b1, 1'b0, adr, 2'b01, 16'h0000, 1'b1, exp, name);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [15:0] dat, input string name);
        xfer(1'b1, 1'b1, 1'b0, adr, 2'b01, dat, 1'b0, 16'h0000, name);
    endtask

    task automatic iack(input logic [15:0] exp, input string name);
        xfer(1'b0, 1'b0, 1'b1, 2'd0, 2'b00, 16'h0000, 1'b1, exp, name);
    endtask

    task automatic pulse(input logic [7:0] m);
        tick();
        irq_in = m;
        tick();
        irq_in = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_tga_i = 1'b0;
        bus.wb_tgc_i = 1'b0;
        bus.wb_adr_i = 2'd0;
        bus.wb_sel_i = 2'b00;
        bus.wb_dat_i = 16'h0000;
        irq_in = 8'h01;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ack", {15'd0, bus.wb_ack_o}, 16'd0);
        chk("rst_dat", bus.wb_dat_o, 16'h0000);
        chk("rst_int_rq", {15'd0, int_rq}, 16'd0);
        rst = 1'b0;
        repeat (4) tick();
        irq_in = 8'h00;

        // Reset values; level held through reset must not latch as pending.
        rd(2'd0, 16'h0020, "rd_vbase");
        rd(2'd1, 16'h00FF, "rd_mask");
        rd(2'd2, 16'h0000, "rd_pend");

        // Single source, timing of int_rq around the ack.
        wr(2'd1, 16'h00FC, "wr_mask_fc");
        pulse(8'h02);
        tick();
        chk("irq1_e1", {15'd0, int_rq}, 16'd0);
        tick();
        chk("irq1_e2", {15'd0, int_rq}, 16'd1);
        iack(16'h0021, "iack_lvl1");
        chk("irq1_ack_cycle", {15'd0, int_rq}, 16'd1);
        tick();
        chk("irq1_fall", {15'd0, int_rq}, 16'd0);
        wr(2'd3, 16'h0000, "eoi_a");

        // Simultaneous sources resolve in priority order.
        wr(2'd1, 16'h0000, "wr_mask_00");
        pulse(8'h03);
        tick();
        tick();
        iack(16'h0020, "iack_first");
        wr(2'd3, 16'h0000, "eoi_b");
        xfer(1'b0, 1'b1, 1'b1, 2'd0, 2'b00, 16'h0000, 1'b1, 16'h0021, "iack_second_tga_tgc");
        wr(2'd3, 16'h0000, "eoi_c");
        chk("both_done_int_rq", {15'd0, int_rq}, 16'd0);

        // Aborted cycle: strobe dropped in WAIT.
        wr(2'd1, 16'h00FF, "wr_mask_ff");
        pulse(8'h04);
        tick();
        tick();
        tick();
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_tga_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 2'd2;
        bus.wb_sel_i = 2'b01;
        bus.wb_dat_i = 16'h0004;
        tick();
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_tga_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_ack", {15'd0, bus.wb_ack_o}, 16'd0);
            tick();
        end
        rd(2'd2, 16'h0004, "abort_pend_kept");
        wr(2'd2, 16'h0004, "clr_pend");
        rd(2'd2, 16'h0000, "pend_cleared");

        // Lane-0 gating and VBASE formatting.
        xfer(1'b1, 1'b1, 1'b0, 2'd0, 2'b10, 16'h0040, 1'b0, 16'h0000, "wr_vbase_lane1");
        rd(2'd0, 16'h0020, "vbase_unchanged");
        wr(2'd0, 16'h0047, "wr_vbase_47");
        rd(2'd0, 16'h0040, "vbase_40");

        // Spurious ack with only masked pending.
        pulse(8'h04);
        tick();
        tick();
        iack(16'h0047, "iack_spurious");
        rd(2'd2, 16'h0004, "spurious_pend_kept");
        chk("masked_int_rq", {15'd0, int_rq}, 16'd0);

        // Unmasking an already pending bit.
        wr(2'd1, 16'h00FB, "wr_mask_fb");
        tick();
        chk("unmask_int_rq", {15'd0, int_rq}, 16'd1);
        iack(16'h0042, "iack_lvl2");
        wr(2'd3, 16'h0000, "eoi_d");
        rd(2'd3, 16'h0000, "rd_isr_idle");
        wr(2'd1, 16'h00FF, "wr_mask_ff2");

        // Edge on the same cycle as a write-1-clear: set wins.
        fork
            wr(2'd2, 16'h0004, "clr_vs_set");
            begin
                tick();
                irq_in = 8'h04;
                tick();
                irq_in = 8'h00;
            end
        join
        rd(2'd2, 16'h0004, "set_wins");
        wr(2'd2, 16'h0004, "clr_pend2");
        rd(2'd2, 16'h0000, "pend_cleared2");

`ifdef M72_IRQ_ISR_EN
        wr(2'd1, 16'h0000, "isr_mask_00");
        pulse(8'h02);
        tick();
        tick();
        iack(16'h0041, "isr_iack1");
        pulse(8'h02);
        tick();
        tick();
        chk("isr_blocked_a", {15'd0, int_rq}, 16'd0);
        tick();
        chk("isr_blocked_b", {15'd0, int_rq}, 16'd0);
        rd(2'd3, 16'h0002, "isr_rd_02");
        wr(2'd3, 16'h0000, "isr_eoi1");
        tick();
        chk("isr_eoi_rise", {15'd0, int_rq}, 16'd1);
        iack(16'h0041, "isr_iack1b");
        tick();
        pulse(8'h01);
        tick();
        chk("isr_pre_e1", {15'd0, int_rq}, 16'd0);
        tick();
        chk("isr_preempt", {15'd0, int_rq}, 16'd1);
        iack(16'h0040, "isr_iack0");
        rd(2'd3, 16'h0003, "isr_rd_03");
        wr(2'd3, 16'h0000, "isr_eoi2");
        rd(2'd3, 16'h0002, "isr_rd_after_eoi");
        wr(2'd3, 16'h0000, "isr_eoi3");
        rd(2'd3, 16'h0000, "isr_rd_empty");
        wr(2'd1, 16'h00FF, "isr_mask_ff");
`endif

        // Reset in the middle of a cycle aborts it.
        tick();
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_tga_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 2'd0;
        bus.wb_sel_i = 2'b01;
        bus.wb_dat_i = 16'h0080;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_no_ack", {15'd0, bus.wb_ack_o}, 16'd0);
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_tga_i = 1'b0;
        rst = 1'b0;
        tick();
        chk("midrst_no_ack2", {15'd0, bus.wb_ack_o}, 16'd0);
        rd(2'd0, 16'h0020, "midrst_vbase");
        rd(2'd1, 16'h00FF, "midrst_mask");

        repeat (5) tick();
        chk("sb_drained", sb_q.size() > 65535 ? 16'hFFFF : 16'(sb_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
